bitonic_sort_ctrl: RTL and testbench
====================================

# bitonic_sort_ctrl

Serial-in/serial-out 8-entry sorter. It loads eight WIDTH-bit values over a valid/ready stream and sorts them ascending with a single shared compare-exchange unit, sequenced through the 24-step bitonic network. It then streams the sorted values out. It is the area-reduced, time-multiplexed counterpart of the fully parallel bitonic merge stages, for paths where throughput of one batch per ~40 cycles is sufficient.

## Interface
- WIDTH, 8, bit width of each value.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input value present.
- in_ready  out  1  block accepts an input this cycle.
- in_data  in  WIDTH  input value.
- out_valid  out  1  sorted value present.
- out_ready  in  1  consumer accepts the output this cycle.
- out_data  out  WIDTH  sorted value, smallest first.
- out_last  out  1  marks the 8th (largest) output of a batch.
- busy  out  1  high in SORT or DRAIN.

## Operation
- Storage is a register array r[0..7] of WIDTH bits, with a 3-bit load/drain index and a 5-bit step counter.
- The FSM has three states.
  - LOAD: in_ready=1. On in_valid&in_ready, r[idx] <= in_data and idx increments. On the 8th accept, go to SORT with step=0 and idx=0.
  - SORT: one compare-exchange per cycle on pair (a,b) from the step table. Ascending direction (asc): if r[a] > r[b], swap. Descending direction (desc): if r[a] < r[b], swap. Equal values are never swapped. After step 23, go to DRAIN.
  - DRAIN: out_valid=1, out_data=r[idx], out_last=(idx==7). On out_valid&out_ready, idx increments. On the handshake with idx==7, go to LOAD with idx=0.
- Step table (0-based indices a,b; direction); steps are numbered consecutively:
  - Steps 0-3: (0,1) asc, (2,3) desc, (4,5) asc, (6,7) desc.
  - Steps 4-7: (0,2) asc, (1,3) asc, (4,6) desc, (5,7) desc.
  - Steps 8-11: (0,1) asc, (2,3) asc, (4,5) desc, (6,7) desc.
  - Steps 12-15: (0,4), (1,5), (2,6), (3,7), all asc.
  - Steps 16-19: (0,2), (1,3), (4,6), (5,7), all asc.
  - Steps 20-23: (0,1), (2,3), (4,5), (6,7), all asc.
- Output decode is combinational from state:
  - in_ready = (state==LOAD).
  - busy = (state!=LOAD).
  - out_valid = (state==DRAIN).
  - out_data is 0 outside DRAIN.
  - out_last is 0 outside DRAIN.
- in_valid is ignored outside LOAD. out_ready is ignored outside DRAIN.
- Batches are not overlapped; the next load starts only after the last drain handshake.

## Timing
- Reset (asynchronous assert) forces:
  - state=LOAD, idx=0, step=0.
  - All r[] cleared to 0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
- Reset mid-LOAD, mid-SORT or mid-DRAIN discards the batch. The first accept after deassertion is element 0.
- Latency: out_valid rises 24 cycles after the edge that accepts the 8th input. That edge is followed by 24 SORT cycles, and the step-23 edge enters DRAIN.
- Minimum batch period is 40 cycles: 8 load + 24 sort + 8 drain.
- While out_ready=0 in DRAIN, out_data and out_last hold stable.
- Gaps in in_valid stretch LOAD without loss. Back-to-back handshakes proceed one per cycle.
- The 8th accept and the transition to SORT happen on the same edge, so in_ready is low in the following cycle.

## Structure
- Package bitonic_pkg contains:
  - N=8 and NSTEPS=24.
  - State enum {LOAD, SORT, DRAIN}.
  - Step-table function step_pair(step) returning {a[2:0], b[2:0], desc}.
- Sub-module bitonic_ce (WIDTH): combinational compare-exchange.
  - Inputs: x, y, desc.
  - Outputs: lo_or_hi ordered pair.
  - Exactly one instance; the controller muxes r[a] and r[b] in and writes both results back.

## Test plan
- Load 8,7,6,5,4,3,2,1 with out_ready=1. Expect outputs 1..8; out_last only with 8; first out_valid 24 cycles after the 8th accept.
- Load 3,3,1,200,0,255,3,1. Expect outputs 0,1,1,3,3,3,200,255 (checks duplicates and extremes).
- Drain with out_ready toggling 1,0,0,1,... on input 10..80 shuffled. Expect out_data to hold during stalls; expect sequence 10,20,...,80.
- Load 5 values, then pulse rst_n low mid-LOAD and reload 8 values. Expect only the new 8, sorted; all outputs 0 and in_ready=1 during reset.
- Assert rst_n low at SORT step 12. Expect busy=0, out_valid=0, and in_ready=1 immediately, with no output ever produced for that batch.
- Two batches back-to-back with in_valid always high. Expect in_ready low for exactly 32 cycles plus stalls; the second batch sorts independently of the first.

Source files
------------

// File: rtl/bitonic_sort_ctrl_pkg.sv
// Shared types and the 24-step bitonic compare-exchange schedule for the
// serial 8-entry sorter.
package bitonic_pkg;

  localparam int unsigned N      = 8;
  localparam int unsigned NSTEPS = 24;

  localparam logic [4:0] LAST_STEP = 5'(NSTEPS - 1);

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } state_t;

  // One network step: compare r[a] with r[b]; desc selects descending order.
  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic       desc;
  } step_t;

  function automatic step_t step_pair(input logic [4:0] step);
    step_t s;
    s = '{a: 3'd0, b: 3'd1, desc: 1'b0};
    case (step)
      // stage 1: sorted pairs in alternating directions
      5'd0:  s = '{a: 3'd0, b: 3'd1, desc: 1'b0};
      5'd1:  s = '{a: 3'd2, b: 3'd3, desc: 1'b1};
      5'd2:  s = '{a: 3'd4, b: 3'd5, desc: 1'b0};
      5'd3:  s = '{a: 3'd6, b: 3'd7, desc: 1'b1};
      // stage 2: merge quads, lower ascending, upper descending
      5'd4:  s = '{a: 3'd0, b: 3'd2, desc: 1'b0};
      5'd5:  s = '{a: 3'd1, b: 3'd3, desc: 1'b0};
      5'd6:  s = '{a: 3'd4, b: 3'd6, desc: 1'b1};
      5'd7:  s = '{a: 3'd5, b: 3'd7, desc: 1'b1};
      5'd8:  s = '{a: 3'd0, b: 3'd1, desc: 1'b0};
      5'd9:  s = '{a: 3'd2, b: 3'd3, desc: 1'b0};
      5'd10: s = '{a: 3'd4, b: 3'd5, desc: 1'b1};
      5'd11: s = '{a: 3'd6, b: 3'd7, desc: 1'b1};
      // stage 3: full ascending merge of the 8-element bitonic sequence
      5'd12: s = '{a: 3'd0, b: 3'd4, desc: 1'b0};
      5'd13: s = '{a: 3'd1, b: 3'd5, desc: 1'b0};
      5'd14: s = '{a: 3'd2, b: 3'd6, desc: 1'b0};
      5'd15: s = '{a: 3'd3, b: 3'd7, desc: 1'b0};
      5'd16: s = '{a: 3'd0, b: 3'd2, desc: 1'b0};
      5'd17: s = '{a: 3'd1, b: 3'd3, desc: 1'b0};
      5'd18: s = '{a: 3'd4, b: 3'd6, desc: 1'b0};
      5'd19: s = '{a: 3'd5, b: 3'd7, desc: 1'b0};
      5'd20: s = '{a: 3'd0, b: 3'd1, desc: 1'b0};
      5'd21: s = '{a: 3'd2, b: 3'd3, desc: 1'b0};
      5'd22: s = '{a: 3'd4, b: 3'd5, desc: 1'b0};
      5'd23: s = '{a: 3'd6, b: 3'd7, desc: 1'b0};
      default: s = '{a: 3'd0, b: 3'd1, desc: 1'b0};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bitonic_sort_ctrl_if.sv
// Input and output value streams of the serial sorter.
interface bitonic_sort_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  // sorter side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  // producer/consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/bitonic_sort_ctrl_ce.sv
// Single compare-exchange cell: orders (x, y) ascending or descending.
// Equal operands are passed through unswapped.
module bitonic_ce #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             desc,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out
);
  logic swap;

  // swap only when the pair is strictly out of the requested order
  always_comb begin
    swap  = desc ? (x < y) : (x > y);
    x_out = swap ? y : x;
    y_out = swap ? x : y;
  end
endmodule

// File: rtl/bitonic_sort_ctrl.sv
// Serial-in/serial-out 8-entry sorter: load 8 values, run the 24-step
// bitonic network through one shared compare-exchange, then stream out.
module bitonic_sort_ctrl
  import bitonic_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bitonic_sort_ctrl_if.slave   bus,
  output logic                 busy
);

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [4:0]       step_q, step_d;
  logic [WIDTH-1:0] r_q [N];
  logic [WIDTH-1:0] r_d [N];

  step_t            sp;
  logic [WIDTH-1:0] ce_x, ce_y;

  // current network step selects the operand pair
  always_comb sp = step_pair(step_q);

  bitonic_ce #(.WIDTH(WIDTH)) u_ce (
    .x     (r_q[sp.a]),
    .y     (r_q[sp.b]),
    .desc  (sp.desc),
    .x_out (ce_x),
    .y_out (ce_y)
  );

  // state, index, step counter and value array registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      idx_q   <= '0;
      step_q  <= '0;
      for (int unsigned i = 0; i < N; i++) r_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      for (int unsigned i = 0; i < N; i++) r_q[i] <= r_d[i];
    end
  end

  // next-state: load, sort one pair per cycle, drain
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step_d  = step_q;
    for (int unsigned i = 0; i < N; i++) r_d[i] = r_q[i];

    case (state_q)
      LOAD: begin
        if (bus.in_valid) begin
          r_d[idx_q] = bus.in_data;
          if (idx_q == 3'd7) begin
            state_d = SORT;
            idx_d   = '0;
            step_d  = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      SORT: begin
        r_d[sp.a] = ce_x;
        r_d[sp.b] = ce_y;
        if (step_q == LAST_STEP) begin
          state_d = DRAIN;
          step_d  = '0;
        end else begin
          step_d = step_q + 5'd1;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (idx_q == 3'd7) begin
            state_d = LOAD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = LOAD;
        idx_d   = '0;
        step_d  = '0;
      end
    endcase
  end

  // stream outputs decoded from state; data and last forced low outside DRAIN
  always_comb begin
    bus.in_ready  = (state_q == LOAD);
    busy          = (state_q != LOAD);
    bus.out_valid = (state_q == DRAIN);
    bus.out_data  = (state_q == DRAIN) ? r_q[idx_q] : '0;
    bus.out_last  = (state_q == DRAIN) && (idx_q == 3'd7);
  end

endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Bench for bitonic_sort_ctrl: table of batches with constant expected
// sorted outputs fed through a scoreboard queue, plus reset and
// back-to-back sequences.
module tb_bitonic_sort_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef logic [7:0] vec_t [8];
  typedef struct {
    vec_t vals;
    vec_t exp;
    bit   stall;
    bit   gaps;
  } tv_t;

  tv_t        tv [5];
  logic [7:0] sb_q [$];

  bitonic_sort_ctrl_if #(.WIDTH(8)) bus ();

  bitonic_sort_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  bus.in_ready,  1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_data"},  bus.out_data,  0);
    chk({tag, "_out_last"},  bus.out_last,  0);
    chk({tag, "_busy"},      busy,          0);
  endtask

  task automatic push_exp(input vec_t e);
    for (int i = 0; i < 8; i++) sb_q.push_back(e[i]);
  endtask

  // drive 8 values; returns the cycle stamp of the 8th accepting edge
  task automatic load(input vec_t v, input bit gaps, output int c_acc);
    for (int i = 0; i < 8; i++) begin
      if (gaps && (i % 2 == 1)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hxx;
        repeat (2) @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = v[i];
      for (int t = 0; t < 100 && !bus.in_ready; t++) begin
        @(posedge clk);
        #1;
      end
      if (!bus.in_ready) chk("load_timeout_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    c_acc = cyc;
    chk("in_ready_after_8th", bus.in_ready, 0);
    chk("busy_after_8th", busy, 1);
  endtask

  // consume 8 outputs, comparing against the scoreboard queue
  task automatic drain(input bit stall, input int c0);
    int         got = 0;
    int         pat = 0;
    bit         first = 1'b1;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_d = '0;
    for (int t = 0; t < 200 && got < 8; t++) begin
      bus.out_ready = stall ? (pat % 3 == 0) : 1'b1;
      if (bus.out_valid) begin
        if (first) chk("first_out_latency", cyc - c0, 24);
        first = 1'b0;
        if (prev_stall) chk("stall_hold_data", bus.out_data, prev_d);
        if (sb_q.size() == 0) begin
          chk("scoreboard_empty", bus.out_valid, 0);
        end else begin
          chk("out_data", bus.out_data, sb_q[0]);
        end
        chk("out_last", bus.out_last, (got == 7) ? 1 : 0);
        if (bus.out_ready) begin
          if (sb_q.size() != 0) void'(sb_q.pop_front());
          got++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_d     = bus.out_data;
        end
        pat++;
      end else begin
        chk("idle_out_data", bus.out_data, 0);
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b0;
    chk("drain_count", got, 8);
    chk("in_ready_after_drain", bus.in_ready, 1);
    chk("busy_after_drain", busy, 0);
  endtask

  initial begin
    int   c0;
    vec_t v;
    vec_t b2b [2];
    vec_t b2b_exp [2];

    tv[0].vals = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    tv[0].exp  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    tv[0].stall = 1'b0; tv[0].gaps = 1'b0;
    tv[1].vals = '{8'd3, 8'd3, 8'd1, 8'd200, 8'd0, 8'd255, 8'd3, 8'd1};
    tv[1].exp  = '{8'd0, 8'd1, 8'd1, 8'd3, 8'd3, 8'd3, 8'd200, 8'd255};
    tv[1].stall = 1'b0; tv[1].gaps = 1'b0;
    tv[2].vals = '{8'd50, 8'd10, 8'd80, 8'd30, 8'd70, 8'd20, 8'd60, 8'd40};
    tv[2].exp  = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    tv[2].stall = 1'b1; tv[2].gaps = 1'b0;
    tv[3].vals = '{8'h0f, 8'hf0, 8'h33, 8'hcc, 8'h55, 8'haa, 8'h01, 8'h80};
    tv[3].exp  = '{8'h01, 8'h0f, 8'h33, 8'h55, 8'h80, 8'haa, 8'hcc, 8'hf0};
    tv[3].stall = 1'b0; tv[3].gaps = 1'b1;
    tv[4].vals = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    tv[4].exp  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    tv[4].stall = 1'b1; tv[4].gaps = 1'b1;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // table-driven batches
    for (int k = 0; k < 5; k++) begin
      push_exp(tv[k].exp);
      load(tv[k].vals, tv[k].gaps, c0);
      drain(tv[k].stall, c0);
    end

    // reset in the middle of LOAD discards partial batch
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 8'd99 - 8'(i);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("midload_in_ready", bus.in_ready, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midload_reset");
    @(posedge clk);
    #1;
    chk_reset_outputs("midload_reset_held");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    v = '{8'd40, 8'd41, 8'd12, 8'd250, 8'd7, 8'd7, 8'd128, 8'd64};
    push_exp('{8'd7, 8'd7, 8'd12, 8'd40, 8'd41, 8'd64, 8'd128, 8'd250});
    load(v, 1'b0, c0);
    drain(1'b0, c0);

    // reset at SORT step 12 drops the batch
    v = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
    load(v, 1'b0, c0);
    repeat (12) @(posedge clk);
    #1;
    chk("sort_busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("sort_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    begin
      int seen = 0;
      int not_ready = 0;
      for (int t = 0; t < 40; t++) begin
        if (bus.out_valid) seen++;
        if (!bus.in_ready) not_ready++;
        @(posedge clk);
        #1;
      end
      chk("sort_reset_no_output", seen, 0);
      chk("sort_reset_stays_load", not_ready, 0);
    end
    bus.out_ready = 1'b0;

    // two batches back-to-back with in_valid held high
    b2b[0]     = '{8'd4, 8'd4, 8'd9, 8'd0, 8'd255, 8'd1, 8'd128, 8'd2};
    b2b_exp[0] = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd4, 8'd9, 8'd128, 8'd255};
    b2b[1]     = '{8'd100, 8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30};
    b2b_exp[1] = '{8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100};
    push_exp(b2b_exp[0]);
    push_exp(b2b_exp[1]);
    begin
      int n_acc = 0;
      int got = 0;
      int low = 0;
      bit acc;
      bus.out_ready = 1'b1;
      for (int t = 0; t < 300 && got < 16; t++) begin
        bus.in_valid = (n_acc < 16);
        bus.in_data  = (n_acc < 16) ? b2b[n_acc / 8][n_acc % 8] : 8'd0;
        if (bus.out_valid) begin
          if (sb_q.size() == 0) begin
            chk("b2b_scoreboard_empty", bus.out_valid, 0);
          end else begin
            chk("b2b_out_data", bus.out_data, sb_q[0]);
            void'(sb_q.pop_front());
          end
          chk("b2b_out_last", bus.out_last, (got % 8 == 7) ? 1 : 0);
          got++;
        end
        if (n_acc == 8 && !bus.in_ready) low++;
        acc = bus.in_valid && bus.in_ready;
        @(posedge clk);
        #1;
        if (acc) n_acc++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      chk("b2b_in_ready_low_cycles", low, 32);
      chk("b2b_out_count", got, 16);
      chk("b2b_accept_count", n_acc, 16);
    end
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
